// File: rtl/gr8ram_phase_tracker.sv
// gr8ram_phase_tracker: locks to delay-gated PHI1 on C7M, produces the S1-S7 bus state,
// refresh slot with make-up debt, and /DEVSEL, /IOSEL, /IOSTRB sampling windows.
// Optional feature macro: GR8RAM_LONGCYCLE_EN (accept 8-cycle stretched periods as good).
module gr8ram_phase_tracker #(
    parameter int LOCKN   = 3,
    parameter int REFPER  = 13,
    parameter int TIMEOUT = 15
) (
    input  logic       C7M,
    input  logic       nRES,
    input  logic       PHI1,
    output logic [2:0] S,
    output logic       Locked,
    output logic       SyncErr,
    output logic       LongCyc,
    output logic       RefSlot,
    output logic [1:0] RefDebt,
    output logic       SelSample,
    output logic       StrbSample
);
    localparam int LW = $clog2(LOCKN + 1);
    localparam int RW = $clog2(REFPER);
    localparam logic [LW-1:0] LKN   = LW'(LOCKN);
    localparam logic [RW-1:0] RLAST = RW'(REFPER - 1);
    localparam logic [3:0]    TMO   = 4'(TIMEOUT);
    localparam logic [3:0]    TMO1  = 4'(TIMEOUT - 1);

    logic          phi1q;
    logic          phi0seen;
    logic [3:0]    p;
    logic [LW-1:0] lockcnt;
    logic [RW-1:0] refcnt;
    logic          rise;
    logic          load;
    logic          meas;
    logic          tmo;
    logic          good;
    logic          long_n;
    logic          bad;
    logic [4:0]    per;
    logic [2:0]    s_n;

    // edge detect, measured period and timeout/lock qualification
    always_comb begin
        rise = PHI1 & ~phi1q;
        load = rise & phi0seen;
        meas = rise & (S != 3'd0);
        per  = {1'b0, p} + 5'd1;
        tmo  = (S != 3'd0) & ~rise & (p == TMO1);
`ifdef GR8RAM_LONGCYCLE_EN
        good   = (per == 5'd7) | (per == 5'd8);
        long_n = (per == 5'd8);
`else
        good   = (per == 5'd7);
        long_n = 1'b0;
`endif
        bad  = meas & ~good;
        s_n  = tmo ? 3'd0 : load ? 3'd1 : ((S == 3'd0) | (S == 3'd7)) ? S : S + 3'd1;
    end

    assign Locked     = (lockcnt == LKN);
    assign SelSample  = Locked & ((S == 3'd4) | (S == 3'd5));
    assign StrbSample = Locked & ((S == 3'd3) | (S == 3'd4) | (S == 3'd5));

    // bus state counter, PHI1-low latch and period counter (restarts at 1 during S1)
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            phi1q    <= 1'b0;
            phi0seen <= 1'b0;
            S        <= 3'd0;
            p        <= 4'd0;
        end else begin
            phi1q    <= PHI1;
            phi0seen <= tmo ? 1'b0 : (phi0seen | ~PHI1);
            S        <= s_n;
            p        <= (S == 3'd1) ? 4'd1 : (p == TMO) ? p : p + 4'd1;
        end
    end

    // lock counting, one-clock sync error pulse and stretched-cycle flag
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            lockcnt <= '0;
            SyncErr <= 1'b0;
            LongCyc <= 1'b0;
        end else begin
            SyncErr <= tmo | bad;
            if (tmo | bad)
                lockcnt <= '0;
            else if (meas & (lockcnt != LKN))
                lockcnt <= lockcnt + LW'(1);
            if (meas)
                LongCyc <= long_n;
        end
    end

    // refresh slot scheduling; slot decided on S1 entry, held through S2, debt repaid when locked
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            refcnt  <= '0;
            RefSlot <= 1'b0;
            RefDebt <= 2'd0;
        end else begin
            if (S == 3'd3)
                refcnt <= (refcnt == RLAST) ? '0 : refcnt + RW'(1);
            if (load) begin
                RefSlot <= Locked & ((refcnt == '0) | (RefDebt != 2'd0));
                if ((refcnt == '0) & ~Locked & (RefDebt != 2'd3))
                    RefDebt <= RefDebt + 2'd1;
                else if ((refcnt != '0) & Locked & (RefDebt != 2'd0))
                    RefDebt <= RefDebt - 2'd1;
            end else if ((S == 3'd2) | tmo)
                RefSlot <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gr8ram_phase_tracker.sv
// tb_gr8ram_phase_tracker: directed self-checking bench for gr8ram_phase_tracker.
module tb_gr8ram_phase_tracker;
    logic       C7M = 1'b0;
    logic       nRES = 1'b0;
    logic       PHI1 = 1'b0;
    logic [2:0] S;
    logic       Locked, SyncErr, LongCyc, RefSlot, SelSample, StrbSample;
    logic [1:0] RefDebt;
    int checks = 0;
    int failures = 0;
    int errs = 0;

    gr8ram_phase_tracker dut (
        .C7M(C7M), .nRES(nRES), .PHI1(PHI1), .S(S), .Locked(Locked),
        .SyncErr(SyncErr), .LongCyc(LongCyc), .RefSlot(RefSlot), .RefDebt(RefDebt),
        .SelSample(SelSample), .StrbSample(StrbSample)
    );

    always #5 C7M = ~C7M;

    // count SyncErr pulses, sampled away from the active edge
    always @(negedge C7M) if (SyncErr) errs++;

    task automatic tick(input logic v);
        PHI1 = v;
        @(posedge C7M);
        #1;
    endtask

    task automatic lows(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge C7M);
        #1;
        checks++;
        if ({S, Locked, SyncErr, LongCyc, RefSlot, RefDebt, SelSample, StrbSample} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {S, Locked, SyncErr, LongCyc, RefSlot, RefDebt, SelSample, StrbSample});
        end
        nRES = 1'b1;
        lows(3);
        checks++;
        if (S !== 3'd0) begin failures++; $display("FAIL idle_s got=%0d want=0", S); end
    endtask

    task automatic test_lock;
        int e0;
        e0 = errs;
        tick(1'b1);
        checks++;
        if (S !== 3'd1 || Locked !== 1'b0) begin failures++; $display("FAIL first_edge s=%0d locked=%b want 1/0", S, Locked); end
        for (int i = 2; i <= 7; i++) begin
            tick(1'b0);
            checks++;
            if (S !== 3'(i)) begin failures++; $display("FAIL s_seq got=%0d want=%0d", S, i); end
        end
        for (int k = 2; k <= 4; k++) begin
            tick(1'b1);
            checks++;
            if (Locked !== (k == 4)) begin failures++; $display("FAIL lock_edge%0d got=%b want=%b", k, Locked, k == 4); end
            if (k < 4) lows(6);
        end
        checks++;
        if (errs !== e0) begin failures++; $display("FAIL lock_syncerr got=%0d pulses want=0", errs - e0); end
    endtask

    task automatic test_bad_period;
        lows(5);
        tick(1'b1);
        checks++;
        if (SyncErr !== 1'b1 || Locked !== 1'b0) begin failures++; $display("FAIL short_period syncerr=%b locked=%b want 1/0", SyncErr, Locked); end
        tick(1'b0);
        checks++;
        if (SyncErr !== 1'b0) begin failures++; $display("FAIL syncerr_pulse got=%b want=0", SyncErr); end
        lows(5);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1);
            checks++;
            if (Locked !== (k == 3)) begin failures++; $display("FAIL relock%0d got=%b want=%b", k, Locked, k == 3); end
            if (k < 3) lows(6);
        end
    endtask

    task automatic test_long_cycle;
        lows(7);
        tick(1'b1);
        checks++;
`ifdef GR8RAM_LONGCYCLE_EN
        if (LongCyc !== 1'b1 || Locked !== 1'b1 || SyncErr !== 1'b0) begin
            failures++; $display("FAIL long_cycle lc=%b locked=%b err=%b want 1/1/0", LongCyc, Locked, SyncErr);
        end
`else
        if (LongCyc !== 1'b0 || Locked !== 1'b0 || SyncErr !== 1'b1) begin
            failures++; $display("FAIL long_cycle lc=%b locked=%b err=%b want 0/0/1", LongCyc, Locked, SyncErr);
        end
`endif
        for (int k = 1; k <= 3; k++) begin
            lows(6);
            tick(1'b1);
        end
        checks++;
        if (Locked !== 1'b1 || LongCyc !== 1'b0) begin failures++; $display("FAIL after_long locked=%b lc=%b want 1/0", Locked, LongCyc); end
    endtask

    task automatic test_timeout;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0);
            if (i == 14) begin
                checks++;
                if (S !== 3'd7 || Locked !== 1'b1 || SyncErr !== 1'b0) begin failures++; $display("FAIL pre_timeout s=%0d locked=%b err=%b want 7/1/0", S, Locked, SyncErr); end
            end
            if (i == 15) begin
                checks++;
                if (S !== 3'd0 || Locked !== 1'b0 || SyncErr !== 1'b1) begin failures++; $display("FAIL timeout s=%0d locked=%b err=%b want 0/0/1", S, Locked, SyncErr); end
            end
            if (i == 16) begin
                checks++;
                if (S !== 3'd0 || SyncErr !== 1'b0) begin failures++; $display("FAIL post_timeout s=%0d err=%b want 0/0", S, SyncErr); end
            end
        end
        tick(1'b1);
        checks++;
        if (S !== 3'd1 || Locked !== 1'b0 || SyncErr !== 1'b0) begin failures++; $display("FAIL restart s=%0d locked=%b err=%b want 1/0/0", S, Locked, SyncErr); end
        for (int k = 1; k <= 3; k++) begin
            lows(6);
            tick(1'b1);
            checks++;
            if (Locked !== (k == 3)) begin failures++; $display("FAIL timeout_relock%0d got=%b want=%b", k, Locked, k == 3); end
        end
    endtask

    task automatic test_windows;
        for (int s = 2; s <= 7; s++) begin
            tick(1'b0);
            checks++;
            if (SelSample !== (s == 4 || s == 5) || StrbSample !== (s >= 3 && s <= 5)) begin
                failures++; $display("FAIL window_s%0d sel=%b strb=%b want %b/%b", s, SelSample, StrbSample, s == 4 || s == 5, s >= 3 && s <= 5);
            end
        end
        tick(1'b1);
        checks++;
        if (SelSample !== 1'b0 || StrbSample !== 1'b0) begin failures++; $display("FAIL window_s1 sel=%b strb=%b want 0/0", SelSample, StrbSample); end
    endtask

    task automatic test_refresh;
        int hits;
        lows(2);
        nRES = 1'b0;
        #1;
        checks++;
        if ({S, Locked, SyncErr, LongCyc, RefSlot, RefDebt, SelSample, StrbSample} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset got=%b want=0", {S, Locked, SyncErr, LongCyc, RefSlot, RefDebt, SelSample, StrbSample});
        end
        @(posedge C7M);
        #1;
        nRES = 1'b1;
        lows(2);
        for (int i = 1; i <= 27; i++) begin
            tick(1'b1);
            if (i == 1) begin
                checks++;
                if (RefDebt !== 2'd1 || RefSlot !== 1'b0) begin failures++; $display("FAIL debt_first debt=%0d slot=%b want 1/0", RefDebt, RefSlot); end
            end
            lows(i == 27 ? 6 : 5);
        end
        for (int i = 28; i <= 30; i++) begin
            tick(1'b1);
            lows(6);
        end
        checks++;
        if (RefDebt !== 2'd3 || Locked !== 1'b1) begin failures++; $display("FAIL debt_accum debt=%0d locked=%b want 3/1", RefDebt, Locked); end
        for (int i = 31; i <= 34; i++) begin
            tick(1'b1);
            checks++;
            if (RefSlot !== (i < 34) || RefDebt !== 2'(i < 33 ? 33 - i : 0)) begin
                failures++; $display("FAIL repay_e%0d slot=%b debt=%0d want %b/%0d", i, RefSlot, RefDebt, i < 34, i < 33 ? 33 - i : 0);
            end
            lows(6);
        end
        hits = 0;
        for (int i = 35; i <= 53; i++) begin
            tick(1'b1);
            if (RefSlot === 1'b1) hits++;
            checks++;
            if (RefSlot !== (i == 40 || i == 53)) begin failures++; $display("FAIL slot_e%0d got=%b want=%b", i, RefSlot, i == 40 || i == 53); end
            if (i == 40) begin
                tick(1'b0);
                checks++;
                if (RefSlot !== 1'b1) begin failures++; $display("FAIL slot_s2 got=%b want=1", RefSlot); end
                tick(1'b0);
                checks++;
                if (RefSlot !== 1'b0) begin failures++; $display("FAIL slot_s3 got=%b want=0", RefSlot); end
                lows(4);
            end else lows(6);
        end
        checks++;
        if (hits !== 2) begin failures++; $display("FAIL slot_count got=%0d want=2", hits); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_lock;
        test_bad_period;
        test_long_cycle;
        test_timeout;
        test_windows;
        test_refresh;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gr8ram_phase_tracker.md
# gr8ram_phase_tracker

Apple II bus-phase tracker for the GR8RAM CPLD. It sits directly upstream of the DRAM/ROM control core. It locks to the delay-gated PHI1 on the 7M clock and produces the S1–S7 state counter that the core decodes for RAS/CAS, register writes and data-bus enables. It also provides the refresh slot, with make-up refreshes after loss of lock, and the legal /DEVSEL, /IOSEL and /IOSTRB sampling windows.

## Interface
- LOCKN, 3: consecutive good PHI1 periods required to assert Locked.
- REFPER, 13: bus cycles per refresh slot (RefCnt runs 0..REFPER-1).
- TIMEOUT, 15: C7M cycles without a PHI1 rising edge before sync is dropped.
- C7M  in  1  7 MHz clock; all state changes on the rising edge.
- nRES  in  1  asynchronous active-low reset.
- PHI1  in  1  delay-gated PHI1 (rising edge already hold-time extended).
- S  out  3  bus state: 0 = unsynced, 1..7 = C7M cycle within bus cycle, saturating at 7.
- Locked  out  1  phase lock achieved.
- SyncErr  out  1  one-cycle pulse on a bad period or timeout.
- LongCyc  out  1  the last measured period was 8 (stretched cycle).
- RefSlot  out  1  refresh permitted this bus cycle; valid from S1 through S2.
- RefDebt  out  2  missed refreshes pending, saturating at 3.
- SelSample  out  1  Locked & (S==4 | S==5).
- StrbSample  out  1  Locked & (S==3 | S==4 | S==5).

## Operation
- PHI1q: registered PHI1. Edge = PHI1 & ~PHI1q.
- PHI0seen: set on any clock with PHI1 == 0. Cleared by reset and by timeout.
- S:
  - S <= 1 on Edge & PHI0seen.
  - Otherwise 0 stays 0, 7 stays 7, and any other value increments.
  - On timeout, S <= 0.
- Period counter P (4 bits):
  - Loads 1 when S enters 1, increments each cycle, saturates at TIMEOUT.
  - On Edge with S != 0, P+1 is the measured period.
  - The first edge after reset or timeout is not measured.
- Good period: 7, or 8 when LONGCYCLE_EN is defined. LongCyc is updated on every measured edge.
- Lock:
  - Each good edge increments LockCnt, saturating at LOCKN. Locked = (LockCnt == LOCKN).
  - A bad edge sets LockCnt <= 0 and Locked <= 0, and pulses SyncErr.
  - Timeout (P == TIMEOUT with no edge) does the same and additionally sets S <= 0 and PHI0seen <= 0.
- Refresh:
  - RefCnt advances at S==3 and wraps REFPER-1 -> 0.
  - On entry to S1 there are four cases:
    - RefCnt == 0 and Locked: RefSlot <= 1.
    - RefCnt == 0 and unlocked: RefDebt++ (saturating), RefSlot <= 0.
    - RefCnt != 0, Locked and RefDebt != 0: RefSlot <= 1 and RefDebt--.
    - Otherwise: RefSlot <= 0.
  - RefSlot clears at S3.
- Reset values: S=0, Locked=0, SyncErr=0, LongCyc=0, RefSlot=0, RefDebt=0, SelSample=0, StrbSample=0; all internal counters 0.

## Timing
- Edge sampled at clock k: S==1 at k, S==2 at k+1, and so on.
- The SelSample and StrbSample windows follow S with no extra latency (combinational from registers).
- Locked asserts on the same clock that S loads 1 for the LOCKN-th good edge.
- SyncErr is high for exactly one clock: the edge clock, or the clock on which P reaches TIMEOUT.
- An edge and a timeout on the same clock: the edge wins and the period is judged normally.
- Reset mid-cycle forces all outputs low asynchronously. Recovery needs one PHI1-low sample and then an edge; lock follows after LOCKN further good periods.
- RefSlot is stable from S1 through the end of S2, so the core may start refresh RAS in S2.

## Configuration
- GR8RAM_LONGCYCLE_EN defined: period 8 counts as good and sets LongCyc=1.
- Not defined: period 8 is bad (SyncErr, lock dropped) and LongCyc stays 0.

## Test plan
- Reset release, then PHI1 with period 7: S runs 1..7 each cycle; Locked rises at the S1 of the 4th edge; SyncErr never asserts.
- Locked, then one period of 6: SyncErr pulses once; Locked=0; it reasserts after 3 further 7-periods.
- Period 8 once, with GR8RAM_LONGCYCLE_EN: LongCyc=1 and Locked stays 1. Without the macro: SyncErr pulses and Locked drops.
- Locked, PHI1 held low for 20 C7M: at P==15, SyncErr=1, S=0, Locked=0. The next edge after a low sample restarts S=1.
- Locked, 13 bus cycles: RefSlot high in S1–S2 exactly once per 13 cycles, when RefCnt==0.
- Unlocked across 3 refresh slots, then lock: RefDebt reads 3. The next 3 locked non-slot cycles assert RefSlot and RefDebt decrements 3->2->1->0.
